fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage ahead of Insmem. Owns the program counter and drives the
//   address into the synchronous instruction memory, which has 1-cycle read latency.
//   Pairs each returned word with its PC and a valid flag for the decoder.
//   Supports decoder back-pressure (stall) and zero-bubble branch/jump redirect.
// PARAMETERS
//   XLEN      32            address/data width
//   RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//   clk             in   1     single clock; all state updates on posedge
//   rst             in   1     asynchronous, active-high reset
//   imem_pc         out  XLEN  byte address to Insmem (Insmem latches mem[imem_pc>>2] on posedge)
//   imem_ins        in   32    Insmem output; the word for the address presented before the last edge
//   dec_ready       in   1     decoder accepts if_* this cycle
//   redirect_valid  in   1     taken branch/jump from execute
//   redirect_pc     in   XLEN  redirect target; bits [1:0] ignored
//   if_valid        out  1     if_ins/if_pc hold a live instruction
//   if_pc           out  XLEN  PC of if_ins
//   if_ins          out  32    instruction; NOP 32'h00000013 when !if_valid
//   fetch_count     out  32    number of instructions accepted by decode (if_valid & dec_ready)
// BEHAVIOUR
//   State: pc_q (next address), req_pc_q (address in flight), req_valid_q, fetch_count.
//   Reset (async, rst=1): pc_q=RESET_PC, req_pc_q=RESET_PC, req_valid_q=0, fetch_count=0;
//     if_valid=0, if_ins=NOP, if_pc=RESET_PC, imem_pc=RESET_PC while rst is held.
//   stall = req_valid_q & ~dec_ready.
//   imem_pc mux, in priority order:
//     redirect_valid -> {redirect_pc[31:2],2'b00}; stall -> req_pc_q; else -> pc_q.
//   On each posedge (rst=0): req_pc_q<=imem_pc; req_valid_q<=1;
//     pc_q<=imem_pc+4 (mod 2^32, wraps from 32'hFFFFFFFC to 0).
//   Re-presenting req_pc_q during a stall keeps imem_ins stable; no holding register.
//   Outputs: if_valid = req_valid_q & ~redirect_valid (the shadow instruction is squashed
//     combinationally); if_pc = req_pc_q; if_ins = if_valid ? imem_ins : NOP.
//   Latency: address presented at edge N -> if_valid/if_ins visible after edge N.
//     Steady state delivers 1 instr/cycle.
//   First edge after reset release fetches RESET_PC. if_valid=1 from that edge on.
//   Redirect: target is fetched at the same edge, so the target is on if_* the next cycle
//     (zero bubble). Redirect beats stall. The squashed instruction is not counted.
//   Redirect during stall: the stalled instruction is dropped and the target is fetched.
//   fetch_count += 1 on edges where if_valid & dec_ready. Wraps modulo 2^32.
//   rst asserted mid-stream: all state clears immediately. Any in-flight word is discarded.
//   No misalignment trap: low redirect bits are forced to 00 silently.
// STRUCTURE
//   Shared package riscv_pkg: XLEN, ILEN=32, RESET_PC, INSN_NOP=32'h00000013, PC_STEP=4.
//   Single module. No sub-module: the PC/next-PC logic is too small to split.
//   Connect imem_pc->Insmem.PC and Insmem.ins->imem_ins.
// TESTING (bench instantiates fetch_unit + Insmem loaded with mem[i]=32'h1000_0000+i)
//   1 Reset: hold rst 3 cycles, release -> if_valid=0 then, one edge later, if_pc=0,
//     if_ins=32'h10000000. imem_pc=0 during reset.
//   2 Stream, dec_ready=1: 6 cycles -> if_pc 0,4,8,12,16,20 with ins 0x10000000..05.
//     fetch_count=6.
//   3 Stall: drop dec_ready for 3 cycles at if_pc=8 -> if_pc=8, if_ins=0x10000002 held
//     3 cycles. Resume with 12. fetch_count excludes stalled cycles.
//   4 Redirect: redirect_valid=1, redirect_pc=32'h0000002B while if_pc=4 -> same cycle
//     if_valid=0. Next cycle if_pc=0x28, if_ins=0x1000000A, then 0x2C. Old PC 8 never appears.
//   5 Redirect during stall: dec_ready=0 at if_pc=16, redirect_pc=0 -> next cycle if_pc=0
//     (instr 16 dropped). fetch_count unchanged by the squash.
//   6 Async reset mid-stream: pulse rst between edges at if_pc=20 -> if_valid=0 and
//     fetch_count=0 immediately, without waiting for an edge. After release, fetch restarts at 0.
//   Also check: PC wrap with RESET_PC=32'hFFFFFFF8 -> PCs FFFFFFF8, FFFFFFFC, 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Purpose : shared RISC-V front-end constants (widths, reset vector, canonical NOP).
// Latency : n/a (constants only).
// Backpressure: n/a.
package riscv_pkg;

   localparam int          XLEN     = 32;
   localparam int          ILEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   // addi x0, x0, 0 -- shown to decode whenever no live instruction is present
   localparam logic [31:0] INSN_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Purpose : instruction-fetch stage; owns the PC, addresses a 1-cycle synchronous
//           instruction memory and pairs each returned word with its PC for decode.
// Latency : address presented before edge N -> if_valid/if_pc/if_ins valid after edge N;
//           1 instr/cycle steady state, zero-bubble redirect.
// Backpressure: dec_ready low re-presents the in-flight address so imem_ins holds;
//           a redirect overrides a stall and squashes the shadow instruction.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_pc   -> Insmem       byte address latched by Insmem on posedge
//   imem_ins  <- Insmem       word for the address presented before the last edge
//   dec_ready <- decode       decode consumes if_* this cycle
//   redirect_valid/_pc <- EX  taken branch/jump target (low two bits ignored)
//   if_valid/if_pc/if_ins ->  instruction handed to decode (NOP when not valid)
//   fetch_count ->            instructions accepted by decode, wraps mod 2^32
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
)
(
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_pc,
   input  logic [31:0]     imem_ins,
   input  logic            dec_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_ins,
   output logic [31:0]     fetch_count
);

   logic [XLEN-1:0] r_pc;          // next sequential address
   logic [XLEN-1:0] r_req_pc;      // address whose word is on imem_ins now
   logic            r_req_vld;     // imem_ins holds a real fetch (low only after reset)
   logic [31:0]     r_fetch_count;

   logic            w_stall;
   logic            w_accept;
   logic [1:0]      w_unused_redirect_lsbs;

   // Misaligned targets are silently word-aligned, so these bits are never used.
   assign w_unused_redirect_lsbs = redirect_pc[1:0];

   assign w_stall = r_req_vld & ~dec_ready;

   // Redirect wins over stall: the stalled word is abandoned and the target fetched
   // at this very edge. During a stall the in-flight address is re-presented so the
   // memory output stays put without a holding register.
   always_comb begin
      if (redirect_valid)
         imem_pc = {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_stall)
         imem_pc = r_req_pc;
      else
         imem_pc = r_pc;
   end

   // The word fetched in the redirect shadow is killed combinationally.
   assign if_valid    = r_req_vld & ~redirect_valid;
   assign if_pc       = r_req_pc;
   assign if_ins      = if_valid ? imem_ins : INSN_NOP;
   assign fetch_count = r_fetch_count;
   assign w_accept    = if_valid & dec_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= RESET_PC;
         r_req_vld     <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         r_req_pc  <= imem_pc;
         r_req_vld <= 1'b1;
         r_pc      <= imem_pc + XLEN'(PC_STEP);
         if (w_accept)
            r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dec_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] imem_pc, imem_ins, if_pc, if_ins, fetch_count;
   logic        if_valid;

   // second instance for PC wrap-around
   logic        wr_rst = 1'b1;
   logic [31:0] wr_imem_pc, wr_imem_ins, wr_if_pc, wr_if_ins, wr_cnt;
   logic        wr_if_valid;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_pc        (imem_pc),
      .imem_ins       (imem_ins),
      .dec_ready      (dec_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_ins         (if_ins),
      .fetch_count    (fetch_count)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk            (clk),
      .rst            (wr_rst),
      .imem_pc        (wr_imem_pc),
      .imem_ins       (wr_imem_ins),
      .dec_ready      (1'b1),
      .redirect_valid (1'b0),
      .redirect_pc    (32'd0),
      .if_valid       (wr_if_valid),
      .if_pc          (wr_if_pc),
      .if_ins         (wr_if_ins),
      .fetch_count    (wr_cnt)
   );

   // Insmem model: mem[i] = 0x1000_0000 + i, one-cycle synchronous read
   always @(posedge clk) begin
      imem_ins    <= 32'h1000_0000 + (imem_pc >> 2);
      wr_imem_ins <= 32'h1000_0000 + (wr_imem_pc >> 2);
   end

   typedef struct {
      bit          rst_first;
      bit          dr;
      bit          rv;
      logic [31:0] rpc;
      bit          e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [31:0] e_imem;
      logic [31:0] e_cnt;
   } vec_t;

   typedef struct {
      bit          vld;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] imem;
      logic [31:0] cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input bit rf, input bit dr, input bit rv, input logic [31:0] rpc,
                      input bit ev, input logic [31:0] epc, input logic [31:0] eins,
                      input logic [31:0] eimem, input logic [31:0] ecnt);
      vec_t v;
      v.rst_first = rf; v.dr = dr; v.rv = rv; v.rpc = rpc;
      v.e_vld = ev; v.e_pc = epc; v.e_ins = eins; v.e_imem = eimem; v.e_cnt = ecnt;
      vecs.push_back(v);
   endtask

   // Called at posedge+1; returns at posedge+1 of the first fetch edge after release.
   task automatic do_reset();
      rst = 1'b1;
      dec_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      for (int k = 0; k < 3; k++) begin
         #3;
         chk("rst_vld",   {31'd0, if_valid}, 32'd0);
         chk("rst_ins",   if_ins, 32'h0000_0013);
         chk("rst_pc",    if_pc, 32'd0);
         chk("rst_imem",  imem_pc, 32'd0);
         chk("rst_count", fetch_count, 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #3;
      chk("rel_vld",  {31'd0, if_valid}, 32'd0);
      chk("rel_imem", imem_pc, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      // rf dr rv rpc          vld pc          ins            imem          cnt
      // stream
      add(1, 1, 0, 32'h0,  1, 32'd0,  32'h10000000, 32'd4,  32'd0);
      add(0, 1, 0, 32'h0,  1, 32'd4,  32'h10000001, 32'd8,  32'd1);
      add(0, 1, 0, 32'h0,  1, 32'd8,  32'h10000002, 32'd12, 32'd2);
      add(0, 1, 0, 32'h0,  1, 32'd12, 32'h10000003, 32'd16, 32'd3);
      add(0, 1, 0, 32'h0,  1, 32'd16, 32'h10000004, 32'd20, 32'd4);
      add(0, 1, 0, 32'h0,  1, 32'd20, 32'h10000005, 32'd24, 32'd5);
      add(0, 1, 0, 32'h0,  1, 32'd24, 32'h10000006, 32'd28, 32'd6);
      // stall three cycles at pc 8
      add(1, 1, 0, 32'h0,  1, 32'd0,  32'h10000000, 32'd4,  32'd0);
      add(0, 1, 0, 32'h0,  1, 32'd4,  32'h10000001, 32'd8,  32'd1);
      add(0, 0, 0, 32'h0,  1, 32'd8,  32'h10000002, 32'd8,  32'd2);
      add(0, 0, 0, 32'h0,  1, 32'd8,  32'h10000002, 32'd8,  32'd2);
      add(0, 0, 0, 32'h0,  1, 32'd8,  32'h10000002, 32'd8,  32'd2);
      add(0, 1, 0, 32'h0,  1, 32'd8,  32'h10000002, 32'd12, 32'd2);
      add(0, 1, 0, 32'h0,  1, 32'd12, 32'h10000003, 32'd16, 32'd3);
      add(0, 1, 0, 32'h0,  1, 32'd16, 32'h10000004, 32'd20, 32'd4);
      // redirect to misaligned 0x2B while pc 4 is shown
      add(1, 1, 0, 32'h0,  1, 32'd0,  32'h10000000, 32'd4,  32'd0);
      add(0, 1, 1, 32'h2B, 0, 32'd4,  32'h00000013, 32'h28, 32'd1);
      add(0, 1, 0, 32'h0,  1, 32'h28, 32'h1000000A, 32'h2C, 32'd1);
      add(0, 1, 0, 32'h0,  1, 32'h2C, 32'h1000000B, 32'h30, 32'd2);
      // redirect to 0 while stalled at pc 16
      add(1, 1, 0, 32'h0,  1, 32'd0,  32'h10000000, 32'd4,  32'd0);
      add(0, 1, 0, 32'h0,  1, 32'd4,  32'h10000001, 32'd8,  32'd1);
      add(0, 1, 0, 32'h0,  1, 32'd8,  32'h10000002, 32'd12, 32'd2);
      add(0, 1, 0, 32'h0,  1, 32'd12, 32'h10000003, 32'd16, 32'd3);
      add(0, 0, 0, 32'h0,  1, 32'd16, 32'h10000004, 32'd16, 32'd4);
      add(0, 0, 1, 32'h0,  0, 32'd16, 32'h00000013, 32'd0,  32'd4);
      add(0, 1, 0, 32'h0,  1, 32'd0,  32'h10000000, 32'd4,  32'd4);
      add(0, 1, 0, 32'h0,  1, 32'd4,  32'h10000001, 32'd8,  32'd5);

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         if (vecs[i].rst_first) do_reset();
         dec_ready      = vecs[i].dr;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         e.vld = vecs[i].e_vld; e.pc = vecs[i].e_pc; e.ins = vecs[i].e_ins;
         e.imem = vecs[i].e_imem; e.cnt = vecs[i].e_cnt;
         sb.push_back(e);
         #3;
         e = sb.pop_front();
         chk($sformatf("v%0d_vld", i),   {31'd0, if_valid}, {31'd0, e.vld});
         chk($sformatf("v%0d_pc", i),    if_pc, e.pc);
         chk($sformatf("v%0d_ins", i),   if_ins, e.ins);
         chk($sformatf("v%0d_imem", i),  imem_pc, e.imem);
         chk($sformatf("v%0d_count", i), fetch_count, e.cnt);
         @(posedge clk); #1;
      end

      // async reset pulse between edges while pc 20 is on if_*
      do_reset();
      dec_ready = 1'b1; redirect_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #3;
         chk($sformatf("ar_pc%0d", k),  if_pc, 32'(4 * k));
         chk($sformatf("ar_ins%0d", k), if_ins, 32'h1000_0000 + 32'(k));
         chk($sformatf("ar_cnt%0d", k), fetch_count, 32'(k));
         if (k < 5) begin
            @(posedge clk); #1;
         end
      end
      rst = 1'b1;
      #1;
      chk("ar_mid_vld",  {31'd0, if_valid}, 32'd0);
      chk("ar_mid_cnt",  fetch_count, 32'd0);
      chk("ar_mid_pc",   if_pc, 32'd0);
      chk("ar_mid_ins",  if_ins, 32'h0000_0013);
      rst = 1'b0;
      #1;
      chk("ar_rel_vld",  {31'd0, if_valid}, 32'd0);
      chk("ar_rel_imem", imem_pc, 32'd0);
      @(posedge clk); #1; #3;
      chk("ar_re_vld", {31'd0, if_valid}, 32'd1);
      chk("ar_re_pc",  if_pc, 32'd0);
      chk("ar_re_ins", if_ins, 32'h1000_0000);
      chk("ar_re_cnt", fetch_count, 32'd0);
      @(posedge clk); #1; #3;
      chk("ar_re_pc1",  if_pc, 32'd4);
      chk("ar_re_cnt1", fetch_count, 32'd1);

      // PC wrap-around from RESET_PC = FFFFFFF8
      @(posedge clk); #1;
      wr_rst = 1'b0;
      #3;
      chk("wr_rel_vld",  {31'd0, wr_if_valid}, 32'd0);
      chk("wr_rel_imem", wr_imem_pc, 32'hFFFF_FFF8);
      @(posedge clk); #1; #3;
      chk("wr_pc0",   wr_if_pc, 32'hFFFF_FFF8);
      chk("wr_ins0",  wr_if_ins, 32'h4FFF_FFFE);
      chk("wr_imem0", wr_imem_pc, 32'hFFFF_FFFC);
      chk("wr_cnt0",  wr_cnt, 32'd0);
      @(posedge clk); #1; #3;
      chk("wr_pc1",   wr_if_pc, 32'hFFFF_FFFC);
      chk("wr_ins1",  wr_if_ins, 32'h4FFF_FFFF);
      chk("wr_imem1", wr_imem_pc, 32'd0);
      chk("wr_cnt1",  wr_cnt, 32'd1);
      @(posedge clk); #1; #3;
      chk("wr_pc2",   wr_if_pc, 32'd0);
      chk("wr_ins2",  wr_if_ins, 32'h1000_0000);
      chk("wr_vld2",  {31'd0, wr_if_valid}, 32'd1);
      chk("wr_cnt2",  wr_cnt, 32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
